// File: rtl/vita49_trig_sched_pkg.sv
// Shared types and helpers for the VITA-49 trigger scheduler: 96-bit timestamp
// type, channel-index width helper and the timestamp compare.
package vita49_trig_sched_pkg;

    localparam int TS_W = 96;

    typedef logic [TS_W-1:0] ts_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Plain unsigned compare; the timestamp is assumed never to wrap.
    function automatic logic ts_ge(input ts_t a, input ts_t b);
        return a >= b;
    endfunction

endpackage

// File: rtl/vita49_trig_sched_chan.sv
// One trigger channel: DEPTH-entry timestamp queue, registered head compare,
// and a pulse counter driving the registered trig/fired/late outputs.
module vita49_trig_sched_chan
    import vita49_trig_sched_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int PULSE_W = 8,
    localparam int CW      = $clog2(DEPTH) + 1,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  ts_t                cur_ts_i,
    input  logic               push_i,
    input  ts_t                push_ts_i,
    input  logic               flush_i,
    input  logic [PULSE_W-1:0] pulse_len_i,
    output logic               full_o,
    output logic [CW-1:0]      count_o,
    output logic               trig_o,
    output logic               fired_o,
    output logic               late_o
);

    ts_t                mem_q [DEPTH];
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               match_q, match_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic               trig_q, trig_d;
    logic               fired_q, fired_d;
    logic               late_q, late_d;

    logic               empty, push_ok, idle, pop, head_due;
    logic [PULSE_W-1:0] len_eff;

    always_comb begin
        full_o   = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push_i && !full_o;
        idle     = (cnt_q == '0) && !trig_q;
        pop      = match_q && idle && !empty && !flush_i;
        head_due = !empty && ts_ge(cur_ts_i, mem_q[rd_q]);
        len_eff  = (pulse_len_i == '0) ? PULSE_W'(1) : pulse_len_i;
    end

    always_comb begin
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop);
        count_d = count_q + CW'(push_ok) - CW'(pop);
        // A pop changes the head, so the stale match must not carry over.
        match_d = head_due && !pop;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        if (pop) begin
            cnt_d  = len_eff;
            trig_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - PULSE_W'(1);
            trig_d = (cnt_q != PULSE_W'(1));
        end
        fired_d = pop;
        late_d  = push_ok && ts_ge(cur_ts_i, push_ts_i);
        // Flush drops everything queued but keeps an entry written this same cycle.
        if (flush_i) begin
            rd_d    = wr_q;
            count_d = CW'(push_ok);
            match_d = 1'b0;
            cnt_d   = '0;
            trig_d  = 1'b0;
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_ts_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            fired_q <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            fired_q <= fired_d;
            late_q  <= late_d;
        end
    end

    assign count_o = count_q;
    assign trig_o  = trig_q;
    assign fired_o = fired_q;
    assign late_o  = late_q;

endmodule

// File: rtl/vita49_trig_sched.sv
// Multi-channel VITA-49 timestamp trigger scheduler: routes schedule entries to
// per-channel queues, gathers backpressure and packs per-channel occupancy.
module vita49_trig_sched
    import vita49_trig_sched_pkg::*;
#(
    parameter  int NUM_CH  = 2,
    parameter  int DEPTH   = 4,
    parameter  int PULSE_W = 8,
    localparam int CH_W    = ch_width(NUM_CH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                 AXIS_ACLK,
    input  logic                 AXIS_ARESETN,
    input  logic [31:0]          tsi,
    input  logic [63:0]          tsf,
    input  logic                 sch_valid,
    output logic                 sch_ready,
    input  logic [CH_W-1:0]      sch_ch,
    input  logic [31:0]          sch_tsi,
    input  logic [63:0]          sch_tsf,
    input  logic [NUM_CH-1:0]    flush,
    input  logic [PULSE_W-1:0]   pulse_len,
    output logic [NUM_CH-1:0]    trig,
    output logic [NUM_CH-1:0]    fired,
    output logic [NUM_CH-1:0]    late,
    output logic [NUM_CH*CW-1:0] fill
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic              ch_ok;
    logic              sel_full;
    ts_t               cur_ts;
    ts_t               push_ts;

    assign cur_ts  = {tsi, tsf};
    assign push_ts = {sch_tsi, sch_tsf};

    // Entries aimed at a nonexistent channel are accepted and dropped.
    always_comb begin
        ch_ok    = int'(sch_ch) < NUM_CH;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sch_ch == CH_W'(i)) begin
                sel_full = full[i];
            end
        end
        sch_ready = AXIS_ARESETN && (!ch_ok || !sel_full);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign push[g] = sch_valid && sch_ready && (sch_ch == CH_W'(g));

        vita49_trig_sched_chan #(
            .DEPTH  (DEPTH),
            .PULSE_W(PULSE_W)
        ) u_chan (
            .clk_i      (AXIS_ACLK),
            .rst_n_i    (AXIS_ARESETN),
            .cur_ts_i   (cur_ts),
            .push_i     (push[g]),
            .push_ts_i  (push_ts),
            .flush_i    (flush[g]),
            .pulse_len_i(pulse_len),
            .full_o     (full[g]),
            .count_o    (fill[g*CW +: CW]),
            .trig_o     (trig[g]),
            .fired_o    (fired[g]),
            .late_o     (late[g])
        );
    end

endmodule

// File: tb/tb_vita49_trig_sched.sv
// Directed bench for vita49_trig_sched (NUM_CH=2, DEPTH=4, PULSE_W=8):
// a table of single-push late/fill vectors plus hand-written pulse sequences.
module tb_vita49_trig_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tsi;
    logic [63:0] tsf;
    logic        sch_valid;
    logic        sch_ready;
    logic [0:0]  sch_ch;
    logic [31:0] sch_tsi;
    logic [63:0] sch_tsf;
    logic [1:0]  flush;
    logic [7:0]  pulse_len;
    logic [1:0]  trig, fired, late;
    logic [5:0]  fill;

    int n_tests = 0;
    int n_fail  = 0;

    vita49_trig_sched #(.NUM_CH(2), .DEPTH(4), .PULSE_W(8)) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESETN(rst_n),
        .tsi         (tsi),
        .tsf         (tsf),
        .sch_valid   (sch_valid),
        .sch_ready   (sch_ready),
        .sch_ch      (sch_ch),
        .sch_tsi     (sch_tsi),
        .sch_tsf     (sch_tsf),
        .flush       (flush),
        .pulse_len   (pulse_len),
        .trig        (trig),
        .fired       (fired),
        .late        (late),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] e_tsi;
        logic [63:0] e_tsf;
        logic [31:0] n_tsi;
        logic [63:0] n_tsf;
        logic        exp_late;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] fill_of(input int ch);
        return fill[ch*3 +: 3];
    endfunction

    task automatic push(input int ch, input logic [31:0] e_tsi, input logic [63:0] e_tsf);
        sch_ch    = 1'(ch);
        sch_tsi   = e_tsi;
        sch_tsf   = e_tsf;
        sch_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !sch_ready; i++) tick();
        check("push_ready", sch_ready, 1);
        tick();
        sch_valid = 1'b0;
    endtask

    task automatic flush_all();
        flush = 2'b11;
        tick();
        flush = 2'b00;
    endtask

    logic tr_trig[16];
    logic tr_fired[16];
    logic [2:0] tr_fill[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'd10,         64'd500,                32'd10,         64'd500,                1'b1};
        vecs[1] = '{0, 32'd10,         64'd501,                32'd10,         64'd500,                1'b0};
        vecs[2] = '{1, 32'd9,          64'hFFFF_FFFF_FFFF_FFFF, 32'd10,         64'd0,                  1'b1};
        vecs[3] = '{1, 32'd11,         64'd0,                  32'd10,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{0, 32'd0,          64'd0,                  32'd0,          64'd0,                  1'b1};
        vecs[5] = '{1, 32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[6] = '{0, 32'h8000_0000,  64'd0,                  32'h7FFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[7] = '{1, 32'd5,          64'h8000_0000_0000_0000, 32'd5,          64'h8000_0000_0000_0001, 1'b1};

        rst_n = 1'b0; tsi = '0; tsf = '0; sch_valid = 1'b1; sch_ch = '0;
        sch_tsi = '0; sch_tsf = '0; flush = '0; pulse_len = 8'd4;
        tick(); tick();
        check("rst_ready", sch_ready, 0);
        check("rst_trig", trig, 0);
        check("rst_fill", fill, 0);
        sch_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", sch_ready, 1);
        check("post_rst_outs", {trig, fired, late}, 0);

        // Single-push late/fill vectors
        for (int i = 0; i < 8; i++) begin
            tsi = vecs[i].n_tsi;
            tsf = vecs[i].n_tsf;
            push(vecs[i].ch, vecs[i].e_tsi, vecs[i].e_tsf);
            check($sformatf("vec%0d_late", i), late[vecs[i].ch], vecs[i].exp_late);
            check($sformatf("vec%0d_late_other", i), late[1 - vecs[i].ch], 0);
            check($sformatf("vec%0d_fill", i), fill_of(vecs[i].ch), 1);
            flush_all();
            check($sformatf("vec%0d_flushed", i), fill, 0);
        end

        // 1: basic fire timing, 4-cycle pulse
        pulse_len = 8'd4; tsi = 32'd10; tsf = 64'd0;
        push(0, 32'd10, 64'd500);
        check("t1_late", late[0], 0);
        for (int c = 0; c < 15; c++) begin
            tsf = 64'(c * 100);
            tick();
            tr_trig[c]  = trig[0];
            tr_fired[c] = fired[0];
        end
        for (int c = 0; c < 15; c++) begin
            check($sformatf("t1_trig_c%0d", c), tr_trig[c], (c >= 6 && c <= 9) ? 1 : 0);
            check($sformatf("t1_fired_c%0d", c), tr_fired[c], (c == 6) ? 1 : 0);
        end
        check("t1_fill", fill_of(0), 0);

        // 2: ch1 full backpressure, release after first pop
        pulse_len = 8'd2; tsi = 32'd10; tsf = 64'd0;
        sch_ch = 1'b1; sch_tsf = '0; sch_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sch_tsi = 32'd1000 + 32'(i);
            #1;
            check($sformatf("t2_ready%0d", i), sch_ready, 1);
            tick();
        end
        check("t2_fill4", fill_of(1), 4);
        sch_tsi = 32'd2000;
        #1;
        check("t2_full_ready", sch_ready, 0);
        tick();
        check("t2_still_full", fill_of(1), 4);
        tsi = 32'd1000;
        tick();
        check("t2_pop_cycle_ready", sch_ready, 0);
        tick();
        check("t2_fill3", fill_of(1), 3);
        check("t2_fired", fired[1], 1);
        check("t2_ready_after_pop", sch_ready, 1);
        tick();
        sch_valid = 1'b0;
        check("t2_fill_refill", fill_of(1), 4);
        flush_all();
        check("t2_flushed", fill_of(1), 0);
        tsi = 32'd10;

        // 3: late push fires from head
        pulse_len = 8'd1; tsf = 64'd0;
        push(0, 32'd5, 64'd0);
        check("t3_late", late[0], 1);
        check("t3_fill", fill_of(0), 1);
        tick();
        check("t3_late_strobe", late[0], 0);
        check("t3_trig_early", trig[0], 0);
        tick();
        check("t3_trig", trig[0], 1);
        check("t3_fired", fired[0], 1);
        tick();
        check("t3_trig_end", trig[0], 0);

        // 4: two entries at the same due time, pulse_len=3
        pulse_len = 8'd3;
        sch_ch = 1'b0; sch_tsi = 32'd7; sch_tsf = 64'd0; sch_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 1) sch_valid = 1'b0;
            tr_trig[c]  = trig[0];
            tr_fired[c] = fired[0];
            tr_fill[c]  = fill_of(0);
        end
        begin
            logic [9:0] e_trig;
            logic [9:0] e_fired;
            logic [2:0] e_fill[10];
            e_trig  = 10'b0111011100;
            e_fired = 10'b0001000100;
            e_fill  = '{3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
            for (int c = 0; c < 10; c++) begin
                check($sformatf("t4_trig_c%0d", c), tr_trig[c], e_trig[c]);
                check($sformatf("t4_fired_c%0d", c), tr_fired[c], e_fired[c]);
                check($sformatf("t4_fill_c%0d", c), tr_fill[c], e_fill[c]);
            end
        end

        // 5: flush mid-pulse with simultaneous push on ch1
        pulse_len = 8'd4;
        push(1, 32'd8, 64'd0);
        tick();
        tick();
        check("t5_trig_on", trig[1], 1);
        check("t5_fired", fired[1], 1);
        tick();
        check("t5_trig_2nd", trig[1], 1);
        flush = 2'b10;
        sch_ch = 1'b1; sch_tsi = 32'd2000; sch_tsf = 64'd0; sch_valid = 1'b1;
        #1;
        check("t5_ready", sch_ready, 1);
        tick();
        flush = 2'b00; sch_valid = 1'b0;
        check("t5_trig_off", trig[1], 0);
        check("t5_fill", fill_of(1), 1);
        check("t5_no_fired", fired[1], 0);
        tick();
        check("t5_no_fired2", {fired[1], trig[1]}, 0);
        check("t5_fill_kept", fill_of(1), 1);
        flush_all();

        // 6: zero pulse length, then reset mid-pulse
        pulse_len = 8'd0;
        push(0, 32'd1, 64'd0);
        tick();
        tick();
        check("t6_trig1", trig[0], 1);
        tick();
        check("t6_trig1_end", trig[0], 0);
        pulse_len = 8'd10;
        push(0, 32'd1, 64'd0);
        tick();
        tick();
        tick();
        check("t6_mid_pulse", trig[0], 1);
        sch_ch = 1'b1; sch_tsi = 32'd2000; sch_tsf = 64'd0; sch_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready_comb", sch_ready, 0);
        tick();
        check("t6_rst_outs", {trig, fired, late}, 0);
        check("t6_rst_fill", fill, 0);
        check("t6_rst_ready", sch_ready, 0);
        sch_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t6_after_rst", {trig, fill}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
